// File: rtl/inst_fetch_buf_pkg.sv
// Shared types and constants for the rvseed instruction fetch buffer.
package inst_fetch_buf_pkg;

   localparam int CPU_WIDTH = 32;
   localparam logic [CPU_WIDTH-1:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [CPU_WIDTH-1:0] pc;
      logic [CPU_WIDTH-1:0] inst;
   } fetch_entry_t;

   // Build a storage entry from the fetch-side fields.
   function automatic fetch_entry_t make_entry(input logic [CPU_WIDTH-1:0] pc,
                                               input logic [CPU_WIDTH-1:0] inst);
      fetch_entry_t e;
      e.pc   = pc;
      e.inst = inst;
      return e;
   endfunction

endpackage

// File: rtl/inst_fetch_buf_sync_fifo_ctrl.sv
// Generic pointer/occupancy control for a power-of-two circular FIFO.
// Flush clears everything and overrides any same-cycle push or pop.
module sync_fifo_ctrl #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   assign full   = (count_q == CNT_MAX);
   assign empty  = (count_q == (PTR_W+1)'(0));
   assign wr_ptr = wr_ptr_q;
   assign rd_ptr = rd_ptr_q;
   assign count  = count_q;

   // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      push_ok_s = push & ~full;
      pop_ok_s  = pop & ~empty;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (flush) begin
         wr_ptr_d = PTR_W'(0);
         rd_ptr_d = PTR_W'(0);
         count_d  = (PTR_W+1)'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         count_q  <= (PTR_W+1)'(0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_MAX);
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty && !flush));

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: in-order {pc, inst} queue between fetch and decode.
// Empty buffer presents a NOP bubble; out_pc keeps the last presented pc.
module inst_fetch_buf
   import inst_fetch_buf_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CPU_WIDTH-1:0] in_pc,
   input  logic [CPU_WIDTH-1:0] in_inst,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CPU_WIDTH-1:0] out_pc,
   output logic [CPU_WIDTH-1:0] out_inst,
   output logic [PTR_W:0]       count
);

   fetch_entry_t         mem_q [DEPTH];
   fetch_entry_t         head_s;
   logic [CPU_WIDTH-1:0] hold_pc_q, hold_pc_d;
   logic [PTR_W-1:0]     wr_ptr_s, rd_ptr_s;
   logic                 full_s, empty_s;
   logic                 push_s, pop_s;

   assign in_ready = ~full_s;
   assign push_s   = in_valid & ~full_s & ~flush;
   assign pop_s    = ~empty_s & out_ready & ~flush;
   assign head_s   = mem_q[rd_ptr_s];

   sync_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .push   (push_s),
      .pop    (pop_s),
      .flush  (flush),
      .wr_ptr (wr_ptr_s),
      .rd_ptr (rd_ptr_s),
      .count  (count),
      .full   (full_s),
      .empty  (empty_s)
   );

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_s] <= make_entry(in_pc, in_inst);
      end
   end

   // Track the pc currently shown so it can be held once the buffer drains.
   always_comb begin
      if (empty_s) begin
         hold_pc_d = hold_pc_q;
      end else begin
         hold_pc_d = head_s.pc;
      end
   end

   // Held-pc register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_pc_q <= 32'h0000_0000;
      end else begin
         hold_pc_q <= hold_pc_d;
      end
   end

   // Decode-side view: head entry, or a NOP bubble when empty.
   always_comb begin
      if (empty_s) begin
         out_valid = 1'b0;
         out_pc    = hold_pc_q;
         out_inst  = INST_NOP;
      end else begin
         out_valid = 1'b1;
         out_pc    = head_s.pc;
         out_inst  = head_s.inst;
      end
   end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Scoreboard bench for inst_fetch_buf: driver queues expected pairs, monitor checks pops.
module tb_inst_fetch_buf;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] INST_KEY = 32'hC0DE_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, in_inst, out_pc, out_inst;
   logic [2:0]  count;

   logic [31:0] exp_q[$];
   bit          pend_push;
   int          checks = 0;
   int          errors = 0;

   inst_fetch_buf dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle at posedge+1; record the expected entry if fetch is accepted.
   task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = pc ^ INST_KEY;
      out_ready = rdy;
      flush     = fl;
      pend_push = !fl && v && in_ready;
      if (fl) exp_q.delete();
      else if (pend_push) exp_q.push_back(pc);
      @(posedge clk);
      #1;
   endtask

   // Monitor: check occupancy, bubble and every consumed entry against the scoreboard.
   always @(negedge clk) begin
      if (!rst && !flush) begin
         chk("count", {29'd0, count}, exp_q.size() - (pend_push ? 1 : 0));
         if (!out_valid) chk("bubble_inst", out_inst, NOP);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_empty: got pc %h expected no output", out_pc);
            end else begin
               chk("out_pc", out_pc, exp_q[0]);
               chk("out_inst", out_inst, exp_q[0] ^ INST_KEY);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = 32'h0; in_inst = 32'h0; pend_push = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_inst", out_inst, NOP);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // Fill to full, overflow push dropped, then drain in order.
      for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 1'b0, 1'b0);
      chk("fill_count", {29'd0, count}, 32'd4);
      chk("fill_ready", {31'd0, in_ready}, 32'd0);
      step(1'b1, 32'h10, 1'b0, 1'b0);
      chk("ovf_count", {29'd0, count}, 32'd4);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_count", {29'd0, count}, 32'd0);
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_hold_pc", out_pc, 32'hC);

      // Streaming: one push and one pop per cycle after the first.
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
         chk("stream_count", {29'd0, count}, 32'd1);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("stream_end", {29'd0, count}, 32'd0);

      // Flush with three entries and a same-cycle push/pop.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + 32'(4 * i), 1'b0, 1'b0);
      chk("preflush_count", {29'd0, count}, 32'd3);
      step(1'b1, 32'h20, 1'b1, 1'b1);
      chk("flush_count", {29'd0, count}, 32'd0);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      step(1'b1, 32'h100, 1'b0, 1'b0);
      chk("post_flush_pc", out_pc, 32'h100);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Full plus pop: push ignored, in_ready returns a cycle later.
      for (int i = 0; i < 4; i++) step(1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b0);
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      step(1'b1, 32'h50, 1'b1, 1'b0);
      chk("fullpop_count", {29'd0, count}, 32'd3);
      chk("fullpop_ready", {31'd0, in_ready}, 32'd1);
      chk("fullpop_head", out_pc, 32'h44);

      // Asynchronous reset mid-run with entries queued.
      step(1'b1, 32'h60, 1'b0, 1'b0);
      in_valid = 1'b0;
      pend_push = 1'b0;
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_inst", out_inst, NOP);
      chk("mid_rst_count", {29'd0, count}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random valid/ready/flush traffic.
      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 31) == 0));
         if (count > 3'd4) chk("rand_count_range", {29'd0, count}, 32'd4);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("final_empty", {29'd0, count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
